// File: rtl/bitstream_sched.sv
// bitstream_sched: shares the BITSTREAM packer between an entropy coder (A)
// and a header/marker inserter (B). Entropy segments are closed with 1-bit
// padding so every header starts on a byte boundary.
module bitstream_sched #(
  parameter int DW = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [LW-1:0] a_length,
  input  logic [DW-1:0] a_data,
  input  logic          a_last,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_len16,
  input  logic [DW-1:0] b_data,
  input  logic          b_last,
  output logic [LW-1:0] bs_ilength,
  output logic [DW-1:0] bs_idata,
  input  logic [2:0]    bs_rest,
  output logic          busy,
  output logic          seg_done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, ENT, HDR, WAIT, ALIGN} state_t;

  localparam logic [LW-1:0] FULL = LW'(DW);
  localparam logic [LW-1:0] HALF = LW'(DW / 2);

  state_t        state, nxt;
  logic [LW-1:0] ilen_nxt;
  logic [DW-1:0] idata_nxt;
  logic          done_nxt;
  logic          err_nxt;

  assign a_ready = (state == ENT);
  assign b_ready = (state == HDR);
  assign busy    = (state != IDLE);

  // Next state and the beat to present to the packer on the next cycle.
  // Any cycle that does not carry a beat or pad drives length 0.
  always_comb begin
    nxt       = state;
    ilen_nxt  = '0;
    idata_nxt = '0;
    done_nxt  = 1'b0;
    err_nxt   = err;
    case (state)
      IDLE: begin
        // Headers precede scan data, so B wins a tie.
        if (b_valid)      nxt = HDR;
        else if (a_valid) nxt = ENT;
      end
      ENT: begin
        if (a_valid) begin
          idata_nxt = a_data;
          if (a_length > FULL) begin
            ilen_nxt = FULL;
            err_nxt  = 1'b1;
          end else begin
            ilen_nxt = a_length;
          end
          if (a_last) nxt = WAIT;
        end
      end
      // One idle beat so the packer's rest reflects the final code bits.
      WAIT: nxt = ALIGN;
      ALIGN: begin
        ilen_nxt  = LW'(bs_rest);
        idata_nxt = '1;
        done_nxt  = 1'b1;
        nxt       = IDLE;
      end
      HDR: begin
        if (b_valid) begin
          ilen_nxt  = b_len16 ? FULL : HALF;
          idata_nxt = b_data;
          if (b_last) begin
            done_nxt = 1'b1;
            nxt      = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State and registered packer-facing outputs; reset discards any partial
  // segment because the packer is reset alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bs_ilength <= '0;
      bs_idata   <= '0;
      seg_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= nxt;
      bs_ilength <= ilen_nxt;
      bs_idata   <= idata_nxt;
      seg_done   <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bitstream_sched.sv
// Bench for bitstream_sched: directed sequences, a vector table of single-beat
// entropy segments, and randomized segments checked against a stream model.
module tb_bitstream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_last;
  logic [4:0]  a_length;
  logic [15:0] a_data;
  logic        b_valid, b_ready, b_len16, b_last;
  logic [15:0] b_data;
  logic [4:0]  bs_ilength;
  logic [15:0] bs_idata;
  logic [2:0]  bs_rest;
  logic        busy, seg_done, err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bitstream_sched #(.DW(16), .LW(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_length(a_length),
    .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_len16(b_len16),
    .b_data(b_data), .b_last(b_last),
    .bs_ilength(bs_ilength), .bs_idata(bs_idata), .bs_rest(bs_rest),
    .busy(busy), .seg_done(seg_done), .err(err)
  );

  // Packer stand-in: total bits consumed; rest = bits to next byte boundary.
  logic [31:0] pk_cnt;
  always @(posedge clk) begin
    if (rst) pk_cnt <= 0;
    else     pk_cnt <= pk_cnt + 32'(bs_ilength);
  end
  assign bs_rest = 3'd0 - pk_cnt[2:0];

  // Capture every non-empty beat and every seg_done pulse.
  logic [20:0] got_q[$];
  int          segs = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bs_ilength != 0) got_q.push_back({bs_ilength, bs_idata});
      if (seg_done) segs++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic send_a(input logic [4:0] l, input logic [15:0] d, input logic last);
    int n = 0;
    a_valid = 1; a_length = l; a_data = d; a_last = last;
    while (!a_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("a_ready_timeout", 0, 1);
    tick();
    a_valid = 0;
  endtask

  task automatic send_b(input logic l16, input logic [15:0] d, input logic last);
    int n = 0;
    b_valid = 1; b_len16 = l16; b_data = d; b_last = last;
    while (!b_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("b_ready_timeout", 0, 1);
    tick();
    b_valid = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 20) begin tick(); n++; end
    if (n >= 20) chk("idle_timeout", 0, 1);
  endtask

  typedef struct {
    logic [4:0]  len;
    logic [15:0] data;
    logic [4:0]  exp_len;
    logic [4:0]  exp_pad;
    logic        exp_err;
  } vec_t;

  vec_t vt[8];

  // Random-phase model state
  logic [20:0] exp_q[$];
  int          tot;
  int          exp_segs;
  logic        exp_err;

  initial begin
    vt[0] = '{5'd3,  16'hFFF0, 5'd3,  5'd5, 1'b0};
    vt[1] = '{5'd16, 16'h2020, 5'd16, 5'd0, 1'b0};
    vt[2] = '{5'd0,  16'h1234, 5'd0,  5'd0, 1'b0};
    vt[3] = '{5'd9,  16'h01FF, 5'd9,  5'd7, 1'b0};
    vt[4] = '{5'd1,  16'h0001, 5'd1,  5'd7, 1'b0};
    vt[5] = '{5'd12, 16'h0ABC, 5'd12, 5'd4, 1'b0};
    vt[6] = '{5'd20, 16'hABCD, 5'd16, 5'd0, 1'b1};
    vt[7] = '{5'd5,  16'h001F, 5'd5,  5'd3, 1'b1};

    rst = 1; a_valid = 0; a_length = 0; a_data = 0; a_last = 0;
    b_valid = 0; b_len16 = 0; b_data = 0; b_last = 0;
    tick(); tick();
    chk("rst_ilen", bs_ilength, 0);
    chk("rst_idata", bs_idata, 0);
    chk("rst_done", seg_done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    rst = 0;
    tick();

    // Aligned entropy: 16,16,0(last); ALIGN issues 0.
    send_a(16, 16'h2020, 0); chk("al_b0", {bs_ilength, bs_idata}, {5'd16, 16'h2020});
    send_a(16, 16'h3030, 0); chk("al_b1", {bs_ilength, bs_idata}, {5'd16, 16'h3030});
    send_a(0, 16'h0000, 1);  chk("al_b2", bs_ilength, 0);
    tick(); chk("al_wait", {bs_ilength, seg_done}, 0);
    tick(); chk("al_align", {bs_ilength, seg_done}, {5'd0, 1'b1});
    tick(); chk("al_end", {busy, seg_done}, 0);

    // Padding and minimum turnaround to a queued header.
    send_a(3, 16'hFFF0, 1); chk("pad_beat", bs_ilength, 3);
    b_valid = 1; b_len16 = 1; b_data = 16'h0505; b_last = 1;
    tick(); chk("pad_wait", {bs_ilength, b_ready}, 0);
    tick(); chk("pad_align", {bs_ilength, bs_idata, seg_done}, {5'd5, 16'hFFFF, 1'b1});
    tick(); chk("pad_idle", {bs_ilength, b_ready}, {5'd0, 1'b1});
    tick(); chk("pad_hdr", {bs_ilength, bs_idata, seg_done}, {5'd16, 16'h0505, 1'b1});
    b_valid = 0;
    tick(); chk("pad_end", busy, 0);

    // Arbitration: B wins, A waits.
    a_valid = 1; a_length = 4; a_data = 16'h000A; a_last = 1;
    b_valid = 1; b_len16 = 0; b_data = 16'h00D0; b_last = 0;
    tick(); chk("arb_grant", {a_ready, b_ready}, 2'b01);
    tick(); chk("arb_b0", {bs_ilength, bs_idata, a_ready}, {5'd8, 16'h00D0, 1'b0});
    b_data = 16'h00E0; b_last = 1;
    tick(); chk("arb_b1", {bs_ilength, bs_idata, seg_done}, {5'd8, 16'h00E0, 1'b1});
    b_valid = 0;
    tick(); chk("arb_a_grant", a_ready, 1);
    tick(); chk("arb_a", bs_ilength, 4);
    a_valid = 0;
    tick(); tick(); chk("arb_pad", {bs_ilength, bs_idata}, {5'd4, 16'hFFFF});
    tick();

    // Stall inside ENT.
    send_a(7, 16'h007F, 0); chk("st_b0", bs_ilength, 7);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("st_gap", {bs_ilength, busy}, {5'd0, 1'b1});
    end
    send_a(1, 16'h0001, 1); chk("st_b1", bs_ilength, 1);
    tick(); chk("st_wait", bs_ilength, 0);
    tick(); chk("st_align", {bs_ilength, seg_done}, {5'd0, 1'b1});
    tick();

    // Vector table of single-beat entropy segments (each starts aligned).
    for (int i = 0; i < 8; i++) begin
      send_a(vt[i].len, vt[i].data, 1);
      chk($sformatf("vt%0d_len", i), bs_ilength, vt[i].exp_len);
      chk($sformatf("vt%0d_data", i), bs_idata, vt[i].data);
      chk($sformatf("vt%0d_err", i), err, vt[i].exp_err);
      tick(); tick();
      chk($sformatf("vt%0d_pad", i), bs_ilength, vt[i].exp_pad);
      if (vt[i].exp_pad != 0) chk($sformatf("vt%0d_padd", i), bs_idata, 16'hFFFF);
      tick();
    end

    // Reset mid-segment: no ALIGN beat, no seg_done, err cleared.
    segs = 0;
    send_a(3, 16'h0007, 0);
    rst = 1; tick(); rst = 0;
    chk("mr_state", {busy, bs_ilength, err}, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("mr_quiet", {bs_ilength, seg_done}, 0);
    end
    chk("mr_segs", segs, 0);

    // Randomized segments against a stream-level model.
    got_q.delete(); segs = 0; tot = 0; exp_segs = 0; exp_err = 0;
    for (int s = 0; s < 60; s++) begin
      int nb = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < nb; k++) begin
          logic [4:0]  l = 5'($urandom_range(0, 18));
          logic [15:0] d = 16'($urandom);
          int eff = (l > 16) ? 16 : int'(l);
          if (l > 16) exp_err = 1;
          if (eff != 0) exp_q.push_back({5'(eff), d});
          tot += eff;
          repeat ($urandom_range(0, 2)) tick();
          send_a(l, d, k == nb - 1);
        end
        if (tot % 8 != 0) begin
          exp_q.push_back({5'(8 - tot % 8), 16'hFFFF});
          tot += 8 - tot % 8;
        end
      end else begin
        for (int k = 0; k < nb; k++) begin
          logic        w = 1'($urandom);
          logic [15:0] d = 16'($urandom);
          exp_q.push_back({w ? 5'd16 : 5'd8, d});
          tot += w ? 16 : 8;
          repeat ($urandom_range(0, 2)) tick();
          send_b(w, d, k == nb - 1);
        end
      end
      exp_segs++;
      wait_idle();
    end
    tick(); tick();
    chk("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rnd_beat%0d", i), got_q[i], exp_q[i]);
    chk("rnd_segs", segs, exp_segs);
    chk("rnd_err", err, exp_err);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
